// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scanner.
//   SEG_OFF    : all segments dark (active-low)
//   HEX_SEG    : hex nibble -> active-low segment pattern, seg[0]=a .. seg[6]=g
//   calc_step  : cycles of lit time per brightness step within one digit slot
package seven_seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // The usable part of a slot (after dead time) is split into 15 equal steps.
  function automatic int calc_step(input int clk_div, input int blank_cycles);
    return (clk_div - blank_cycles) / 15;
  endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Bundle between the datapath status registers and the display scanner.
//   master : drives display content/controls, observes pins
//   slave  : the scanner; consumes content, drives anode/segment pins
// Signals: en, disp[4N-1:0], dp[N-1:0], blank[N-1:0], bright[3:0], lzs
//          an[N-1:0], seg[6:0], dp_n, frame_start
interface seven_seg_scanner_if #(
  parameter int N_DIGITS = 4
);
  logic                  en;
  logic [4*N_DIGITS-1:0] disp;
  logic [N_DIGITS-1:0]   dp;
  logic [N_DIGITS-1:0]   blank;
  logic [3:0]            bright;
  logic                  lzs;
  logic [N_DIGITS-1:0]   an;
  logic [6:0]            seg;
  logic                  dp_n;
  logic                  frame_start;

  modport master (
    output en, disp, dp, blank, bright, lzs,
    input  an, seg, dp_n, frame_start
  );

  modport slave (
    input  en, disp, dp, blank, bright, lzs,
    output an, seg, dp_n, frame_start
  );
endinterface

// File: rtl/seven_seg_hex_decode.sv
// Combinational hex-to-seven-segment decoder, active-low outputs.
//   nibble : 4-bit hex value in
//   seg    : segments a..g on seg[0]..seg[6], 0 = lit
module seven_seg_hex_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = HEX_SEG[nibble];
endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed N-digit common-anode seven-segment scanner.
// One digit per slot of CLK_DIV cycles; slot 0 is the leftmost digit.
// Inputs are snapshotted once per frame so a frame is always coherent.
// Each slot opens with BLANK_CYCLES of dead time, then a brightness-scaled
// lit window. All pin outputs are registered (one cycle of latency).
//   clk, rst : clock and synchronous active-high reset
//   bus      : seven_seg_scanner_if slave (content in, pins out)
// Optional: define SEVEN_SEG_LZS_EN to enable leading-zero suppression
// (bus.lzs); without it bus.lzs is ignored.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int CLK_DIV      = 32,
  parameter int BLANK_CYCLES = 2
) (
  input logic               clk,
  input logic               rst,
  seven_seg_scanner_if.slave bus
);
  localparam int TW      = $clog2(CLK_DIV);
  localparam int SW      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int STEP    = calc_step(CLK_DIV, BLANK_CYCLES);
  localparam int ON_FULL = CLK_DIV - BLANK_CYCLES;

  logic [TW-1:0]         tick_q, tick_d;
  logic [SW-1:0]         slot_q, slot_d;
  logic [4*N_DIGITS-1:0] disp_sh_q, disp_sh_d;
  logic [N_DIGITS-1:0]   dp_sh_q, dp_sh_d;
  logic [N_DIGITS-1:0]   blank_sh_q, blank_sh_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_n_q, dp_n_d;
  logic                  snap_q;
  logic                  frame_start_q;

  logic                  tick_wrap, slot_wrap, snap;
  logic [SW-1:0]         dig_idx;
  logic [3:0]            nibble;
  logic [6:0]            dec_seg;
  logic [N_DIGITS-1:0]   supp;
  logic [3:0]            nib_arr [N_DIGITS];

  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_nib
      assign nib_arr[gi] = disp_sh_q[4*gi +: 4];
    end
  endgenerate

`ifdef SEVEN_SEG_LZS_EN
  logic [N_DIGITS-1:0] nib_zero;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_lzs
      assign nib_zero[gi] = (nib_arr[gi] == 4'h0);
      if (gi == 0) begin : g_last
        // Rightmost digit always shows, so an all-zero word still reads "0".
        assign supp[gi] = 1'b0;
      end else begin : g_sup
        // Dark when this nibble and every nibble to its left are zero.
        assign supp[gi] = bus.lzs && (&nib_zero[N_DIGITS-1:gi]) && !dp_sh_q[gi];
      end
    end
  endgenerate
`else
  logic unused_lzs;
  assign unused_lzs = bus.lzs;
  assign supp       = '0;
`endif

  seven_seg_hex_decode u_dec (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  always_comb begin
    tick_wrap = (tick_q == TW'(CLK_DIV - 1));
    slot_wrap = (slot_q == SW'(N_DIGITS - 1));
    snap      = tick_wrap && slot_wrap;

    tick_d = tick_wrap ? '0 : tick_q + 1'b1;
    slot_d = slot_q;
    if (tick_wrap) slot_d = slot_wrap ? '0 : slot_q + 1'b1;

    disp_sh_d  = snap ? bus.disp  : disp_sh_q;
    dp_sh_d    = snap ? bus.dp    : dp_sh_q;
    blank_sh_d = snap ? bus.blank : blank_sh_q;

    // Slot 0 maps to the most significant (leftmost) digit index.
    dig_idx = SW'(N_DIGITS - 1) - slot_q;
    nibble  = nib_arr[dig_idx];
  end

  // Lit-window decision uses live en/bright so they act without waiting
  // for a frame boundary; content comes only from the shadow registers.
  always_comb begin
    int  on_cycles;
    int  tick_i;
    logic active;

    on_cycles = (bus.bright == 4'hF) ? ON_FULL : int'(bus.bright) * STEP;
    tick_i    = int'(tick_q);
    active    = (tick_i >= BLANK_CYCLES) && (tick_i < BLANK_CYCLES + on_cycles)
                && bus.en && !blank_sh_q[dig_idx] && !supp[dig_idx];

    an_d   = '1;
    seg_d  = SEG_OFF;
    dp_n_d = 1'b1;
    if (active) begin
      an_d[dig_idx] = 1'b0;
      seg_d         = dec_seg;
      dp_n_d        = ~dp_sh_q[dig_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q        <= '0;
      slot_q        <= '0;
      disp_sh_q     <= '0;
      dp_sh_q       <= '0;
      blank_sh_q    <= '1;
      an_q          <= '1;
      seg_q         <= SEG_OFF;
      dp_n_q        <= 1'b1;
      snap_q        <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      tick_q        <= tick_d;
      slot_q        <= slot_d;
      disp_sh_q     <= disp_sh_d;
      dp_sh_q       <= dp_sh_d;
      blank_sh_q    <= blank_sh_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_n_q        <= dp_n_d;
      // Two stages: snap -> counters at slot 0/tick 0 -> registered pins.
      snap_q        <= snap;
      frame_start_q <= snap_q;
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.dp_n        = dp_n_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
Parametrised time-multiplexed driver for an N-digit common-anode seven-segment display. It takes a packed hex word, per-digit decimal points and per-digit blank masks, and scans one digit per slot. Features over the earlier fixed 4-digit scanner:
- configurable digit count and refresh prescaler;
- frame-coherent input snapshot;
- anti-ghosting dead time and brightness PWM.

It sits between the datapath status registers and the board display pins.

Parameters:
N_DIGITS, 4, number of digits scanned (1..8)
CLK_DIV, 32, clk cycles per digit slot (>= BLANK_CYCLES+15)
BLANK_CYCLES, 2, dead-time cycles at slot start with all anodes off

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
en  in  1  display enable; 0 forces anodes off, counters keep running
disp  in  4*N_DIGITS  hex nibbles; [4*N_DIGITS-1 -: 4] = leftmost digit
dp  in  N_DIGITS  decimal point per digit, 1 = lit; bit N_DIGITS-1 = leftmost
blank  in  N_DIGITS  per-digit force-dark, 1 = dark
bright  in  4  brightness 0..15
lzs  in  1  leading-zero suppression request (used only with macro)
an  out  N_DIGITS  anodes, active-low
seg  out  7  segments a..g on seg[0]..seg[6], active-low
dp_n  out  1  decimal point, active-low
frame_start  out  1  one-cycle pulse at start of each scan frame

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - tick_cnt = 0, slot = 0;
  - shadow disp = 0, shadow dp = 0, shadow blank = all ones;
  - an = all ones, seg = 7'h7F, dp_n = 1, frame_start = 0.
- Prescaler:
  - tick_cnt counts 0..CLK_DIV-1, then wraps to 0.
  - On wrap, slot advances; slot wraps from N_DIGITS-1 to 0.
  - Slot i drives an[N_DIGITS-1-i] with nibble/dp/blank at index N_DIGITS-1-i, so slot 0 is the leftmost digit.
- Snapshot:
  - Trigger: the cycle where tick_cnt == CLK_DIV-1 and slot == N_DIGITS-1.
  - On that cycle, disp, dp and blank are captured into shadow registers.
  - Registered frame_start pulses high for 1 cycle, coincident with slot 0's first output cycle.
  - The first frame after reset is fully dark.
  - Input changes mid-frame are never visible until the next frame.
- Active window:
  - STEP = (CLK_DIV-BLANK_CYCLES)/15, integer floor.
  - on_cycles = CLK_DIV-BLANK_CYCLES when bright == 15, else bright*STEP.
  - The digit is active when BLANK_CYCLES <= tick_cnt < BLANK_CYCLES+on_cycles, en = 1, and shadow blank bit = 0 (and not suppressed).
  - bright = 0 means always dark.
- Output (all registered):
  - Outputs in cycle t+1 reflect counters and shadow in cycle t, i.e. 1-cycle latency.
  - Active digit: its anode is low, all others high; seg = decoded nibble; dp_n = ~dp bit.
  - Inactive: an all ones, seg = 7'h7F, dp_n = 1.
  - At most one anode is ever low.
- Decode (active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
- Boundary cases:
  - rst mid-slot returns everything to reset values next cycle.
  - bright or en changes take effect at the next cycle, not deferred to the frame.
  - N_DIGITS = 1: every slot wrap is a frame boundary.

Optional Feature:
SEVEN_SEG_LZS_EN
- Defined: when lzs = 1, digit k (counted from leftmost) is treated as blank if its shadow nibble and all nibbles left of it are 0 and its shadow dp is 0.
- The rightmost digit is never suppressed.
- Suppression is evaluated on shadow values.
- Undefined: lzs is ignored and zeros display normally.

Decomposition:
Package seven_seg_pkg holds:
- SEG_OFF = 7'h7F;
- the 16-entry decode constant table;
- a function computing STEP.

Sub-module seven_seg_hex_decode (4-bit nibble in, 7-bit active-low segments out, combinational) is instantiated once.

Test Plan:
- rst held 3 cycles, then released (N_DIGITS=4, CLK_DIV=32, BLANK=2, bright=15, en=1) -> an=4'hF, seg=7'h7F for the first full frame (128 cycles); frame_start pulses at cycle 128 after release.
- disp=16'h12AF, dp=4'b0010, blank=0 -> frame 2:
  - slot0: an=4'b0111, seg=79;
  - slot1: an=4'b1011, seg=24;
  - slot2: an=4'b1101, seg=08, dp_n=0;
  - slot3: an=4'b1110, seg=0E;
  - each anode low for 30 of 32 cycles, high for cycles 0-1.
- bright=5 -> each anode low for exactly 10 cycles per slot (STEP=2); bright=0 -> an stays 4'hF.
- disp changed from 16'h1111 to 16'h2222 mid-frame -> remainder of frame shows 1s; next frame shows 2s.
- blank=4'b1000 and en toggled to 0 mid-slot -> leftmost digit never lit; en=0 gives an=4'hF from the next cycle.
- Macro defined, lzs=1, disp=16'h0070 -> digits 0 and 1 dark, digit 2 shows 7, digit 3 shows 0; disp=16'h0000 -> only the rightmost digit shows 0.
